// File: rtl/button_event_pkg.sv
// button_event_pkg: shared types and constants for the button event block.
//   state_e            FSM states (IDLE, HOLD, REPEAT)
//   DEF_HOLD_CYCLES    default hold time before the first auto-repeat
//   DEF_REPEAT_CYCLES  default period between auto-repeats
//   REPEAT_CNT_W       width of the saturating repeat counter output
package button_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

    localparam int DEF_HOLD_CYCLES   = 50_000_000;
    localparam int DEF_REPEAT_CYCLES = 10_000_000;
    localparam int REPEAT_CNT_W      = 8;

endpackage

// File: rtl/button_event_level_edge.sv
// level_edge: registers a synchronous level and reports its rising and
// falling edges. The previous-level flop presets to 1 so that an input
// already high when reset releases is not mistaken for a new press.
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-high reset
//   level_in  in   level, synchronous to clk
//   rise      out  level_in=1 while previous sample was 0 (combinational)
//   fall      out  level_in=0 while previous sample was 1 (combinational)
module level_edge (
    input  logic clk,
    input  logic reset,
    input  logic level_in,
    output logic rise,
    output logic fall
);

    logic level_prev_q, level_prev_d;

    always_comb level_prev_d = level_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) level_prev_q <= 1'b1;
        else       level_prev_q <= level_prev_d;
    end

    assign rise = level_in & ~level_prev_q;
    assign fall = ~level_in & level_prev_q;

endmodule

// File: rtl/button_event.sv
// button_event: turns a debounced button level into one-cycle press,
// release and timed auto-repeat pulses. One instance per button.
// Optional feature: define BUTTON_EVENT_AUTO_REPEAT_EN to build the
// auto-repeat timer; without it only press/release are produced and
// repeat_pulse / repeat_cnt are tied to 0.
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-high reset
//   level_in       in   debounced level, 1 = pressed
//   press_pulse    out  one cycle on an accepted press
//   release_pulse  out  one cycle on release of an accepted press
//   repeat_pulse   out  one cycle per auto-repeat tick
//   event_pulse    out  press or repeat; the "advance field" strobe
//   held           out  high while a press is being held
//   repeat_cnt     out  repeats in the current hold, saturating at 255
module button_event
    import button_event_pkg::*;
#(
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int CNT_W         = 26
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    level_in,
    output logic                    press_pulse,
    output logic                    release_pulse,
    output logic                    repeat_pulse,
    output logic                    event_pulse,
    output logic                    held,
    output logic [REPEAT_CNT_W-1:0] repeat_cnt
);

    // Reject configurations where the timer cannot reach its terminal count.
    if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2 ||
        HOLD_CYCLES >= (1 << CNT_W) || REPEAT_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
        $error("button_event: illegal HOLD_CYCLES/REPEAT_CYCLES/CNT_W");
    end

    logic rise, fall;

    level_edge u_edge (
        .clk      (clk),
        .reset    (reset),
        .level_in (level_in),
        .rise     (rise),
        .fall     (fall)
    );

    state_e state_q, state_d;
    logic   press_q, press_d;
    logic   release_q, release_d;
    logic   event_q, event_d;

`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
    logic                    repeat_q, repeat_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_lim;
    logic [REPEAT_CNT_W-1:0] rcnt_q, rcnt_d;

    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        cnt_d     = cnt_q;
        rcnt_d    = rcnt_q;
        cnt_lim   = (state_q == ST_HOLD) ? CNT_W'(HOLD_CYCLES - 1)
                                         : CNT_W'(REPEAT_CYCLES - 1);
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    cnt_d   = '0;
                    rcnt_d  = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                // A fall takes priority over a simultaneous timer expiry.
                if (fall) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else if (cnt_q == cnt_lim) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                    if (rcnt_q != '1) rcnt_d = rcnt_q + 1'b1;
                    state_d  = ST_REPEAT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        event_d = press_d | repeat_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            repeat_q <= 1'b0;
            cnt_q    <= '0;
            rcnt_q   <= '0;
        end else begin
            repeat_q <= repeat_d;
            cnt_q    <= cnt_d;
            rcnt_q   <= rcnt_d;
        end
    end

    assign repeat_pulse = repeat_q;
    assign repeat_cnt   = rcnt_q;
`else
    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (fall) begin
                    release_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        event_d = press_d;
    end

    assign repeat_pulse = 1'b0;
    assign repeat_cnt   = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            event_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            event_q   <= event_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign event_pulse   = event_q;
    assign held          = (state_q != ST_IDLE);

endmodule
